// File: rtl/a4_window_acc.sv
// a4_window_acc: sums non-overlapping windows of N signed 6-bit samples and
// tracks the window min/max, presenting one result per window on a
// valid/ready output port.
// Optional feature: define A4_WINDOW_ACC_SATURATE_EN to clamp out_sum to the
// 6-bit signed range and flag the clamp on out_sat.
module a4_window_acc #(
  parameter int N     = 4,
  parameter int SUM_W = 6 + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [5:0]       in_z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [SUM_W-1:0] out_sum,
  output logic signed [5:0]       out_min,
  output logic signed [5:0]       out_max,
  output logic                    out_sat
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t                  state, state_nx;
  logic signed [SUM_W-1:0] acc, acc_base, sum_nx, res_sum;
  logic signed [SUM_W-1:0] z_ext;
  logic signed [5:0]       mn, mx, min_nx, max_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic                    accept, done, res_sat;

`ifdef A4_WINDOW_ACC_SATURATE_EN
  localparam logic signed [SUM_W-1:0] SMAX = SUM_W'(31);
  localparam logic signed [SUM_W-1:0] SMIN = SUM_W'(-32);
`endif

  // Handshake decode and next window values; IDLE starts from an empty window.
  always_comb begin
    in_ready  = (state != HOLD);
    out_valid = (state == HOLD);
    accept    = in_valid && in_ready && !clear;
    z_ext     = {{(SUM_W-6){in_z[5]}}, in_z};
    acc_base  = (state == ACC) ? acc : '0;
    sum_nx    = acc_base + z_ext;
    min_nx    = in_z;
    max_nx    = in_z;
    if (state == ACC) begin
      if (mn < in_z) min_nx = mn;
      if (mx > in_z) max_nx = mx;
    end
    cnt_nx    = (state == ACC) ? cnt + CW'(1) : CW'(1);
    done      = accept && (cnt_nx == CW'(N));
  end

  // Result formatting: full precision, or clamped to 6-bit signed when enabled.
  always_comb begin
    res_sum = sum_nx;
    res_sat = 1'b0;
`ifdef A4_WINDOW_ACC_SATURATE_EN
    if (sum_nx > SMAX) begin
      res_sum = SMAX;
      res_sat = 1'b1;
    end else if (sum_nx < SMIN) begin
      res_sum = SMIN;
      res_sat = 1'b1;
    end
`endif
  end

  // Next-state logic; clear overrides both accept and output handshake.
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, ACC: if (accept) state_nx = done ? HOLD : ACC;
        HOLD:      if (out_ready) state_nx = IDLE;
        default:   state_nx = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Running window accumulator, min/max and sample count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      mn  <= '0;
      mx  <= '0;
      cnt <= '0;
    end else if (clear || (state == HOLD && out_ready)) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= sum_nx;
      mn  <= min_nx;
      mx  <= max_nx;
      cnt <= cnt_nx;
    end
  end

  // Result registers load once per window and hold until the next window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum <= '0;
      out_min <= '0;
      out_max <= '0;
      out_sat <= 1'b0;
    end else if (done) begin
      out_sum <= res_sum;
      out_min <= min_nx;
      out_max <= max_nx;
      out_sat <= res_sat;
    end
  end

endmodule
